// File: rtl/hazard_scoreboard_if.sv
// ----------------------------------------------------------------------------
// hazard_scoreboard_if
//   Bundles the decode-stage signals between the ID stage (master) and the
//   hazard/forwarding controller (slave).
//   master drives : id_valid, id_rs, id_rs_used, id_rd, id_regwrite,
//                   id_is_load, id_long, flush, lw_valid, lw_rd
//   slave drives  : stall, fwd_sel, long_busy, stall_cnt
// ----------------------------------------------------------------------------
interface hazard_scoreboard_if #(
    parameter int NUM_REGS = 32,
    parameter int RW       = 5,
    parameter int NUM_SRC  = 2
);
    logic                    id_valid;
    logic [NUM_SRC*RW-1:0]   id_rs;
    logic [NUM_SRC-1:0]      id_rs_used;
    logic [RW-1:0]           id_rd;
    logic                    id_regwrite;
    logic                    id_is_load;
    logic                    id_long;
    logic                    flush;
    logic                    lw_valid;
    logic [RW-1:0]           lw_rd;
    logic                    stall;
    logic [NUM_SRC*2-1:0]    fwd_sel;
    logic [NUM_REGS-1:0]     long_busy;
    logic [15:0]             stall_cnt;

    modport master (
        output id_valid, id_rs, id_rs_used, id_rd, id_regwrite, id_is_load,
               id_long, flush, lw_valid, lw_rd,
        input  stall, fwd_sel, long_busy, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rs_used, id_rd, id_regwrite, id_is_load,
               id_long, flush, lw_valid, lw_rd,
        output stall, fwd_sel, long_busy, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// ----------------------------------------------------------------------------
// hazard_scoreboard
//   Decode-stage hazard and forwarding controller for the 5-stage core.
//   Shadows the destinations of the instructions in EX and MEM, keeps busy
//   bits for outstanding long (mul/div) ops, raises a combinational stall
//   request and presents registered per-operand forward selects together
//   with the instruction as it sits in EX.
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous reset, active low
//   sb     : hazard_scoreboard_if.slave
//            in  id_valid/id_rs/id_rs_used/id_rd/id_regwrite/id_is_load/
//                id_long  - instruction in ID
//            in  flush    - squash the instruction in ID
//            in  lw_valid/lw_rd - long-op writeback
//            out stall    - hold PC and IF/ID, bubble into EX
//            out fwd_sel  - per operand: 00 regfile, 10 EX/MEM, 01 MEM/WB
//            out long_busy- scoreboard busy bits
//            out stall_cnt- saturating count of stall cycles
// ----------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int RW       = 5,
    parameter int NUM_SRC  = 2,
    parameter int MAX_LONG = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    hazard_scoreboard_if.slave sb
);
    localparam int            CW        = $clog2(MAX_LONG + 1);
    localparam logic [CW-1:0] LONG_FULL = CW'(MAX_LONG);

    logic [RW-1:0]        rd_p1;
    logic                 wr_p1;
    logic                 ld_p1;
    logic [RW-1:0]        rd_p2;
    logic                 wr_p2;
    logic [NUM_SRC*2-1:0] fwd_sel_p1;
    logic [NUM_SRC*2-1:0] fwd_nxt;
    logic [NUM_REGS-1:0]  busy;
    logic [NUM_REGS-1:0]  busy_nxt;
    logic [CW-1:0]        long_cnt;
    logic [CW-1:0]        long_cnt_nxt;
    logic [15:0]          stall_cnt_q;
    logic [RW-1:0]        src_idx;
    logic                 src_hz;
    logic                 waw_hz;
    logic                 full_hz;
    logic                 stall_c;
    logic                 issue;
    logic                 adv_ex;
    logic                 set_busy;
    logic                 clr_busy;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // ID stage: operand hazards and forward-select candidates
    always_comb begin
        src_hz  = 1'b0;
        fwd_nxt = '0;
        src_idx = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_idx = sb.id_rs[i*RW +: RW];
            if (sb.id_rs_used[i] && src_idx != '0) begin
                if (ld_p1 && wr_p1 && rd_p1 == src_idx) src_hz = 1'b1;
                if (busy[src_idx])                      src_hz = 1'b1;
            end
            // EX producer is newer than MEM producer, so it is tested first
            if (wr_p1 && rd_p1 != '0 && rd_p1 == src_idx)
                fwd_nxt[2*i +: 2] = 2'b10;
            else if (wr_p2 && rd_p2 != '0 && rd_p2 == src_idx)
                fwd_nxt[2*i +: 2] = 2'b01;
        end
    end

    // A long op is checked for WAW as well so a destination is never
    // claimed twice in the scoreboard.
    assign waw_hz  = (sb.id_regwrite || sb.id_long) && sb.id_rd != '0 && busy[sb.id_rd];
    // x0 long ops take no slot, so they never wait for one
    assign full_hz = sb.id_long && sb.id_rd != '0 && long_cnt == LONG_FULL;
    assign stall_c = rst_n && sb.id_valid && !sb.flush && (src_hz || waw_hz || full_hz);

    assign issue    = sb.id_valid && !stall_c && !sb.flush;
    assign adv_ex   = issue && !sb.id_long;
    assign set_busy = issue && sb.id_long && sb.id_rd != '0;
    // Writebacks for regs that are not pending are ignored entirely
    assign clr_busy = sb.lw_valid && sb.lw_rd != '0 && busy[sb.lw_rd];

    always_comb begin
        busy_nxt     = busy;
        long_cnt_nxt = long_cnt;
        if (clr_busy) busy_nxt[sb.lw_rd] = 1'b0;
        if (set_busy) busy_nxt[sb.id_rd] = 1'b1;
        if (set_busy && !clr_busy)
            long_cnt_nxt = long_cnt + 1'b1;
        else if (clr_busy && !set_busy)
            long_cnt_nxt = long_cnt - 1'b1;
    end

    // ID -> EX -> MEM shadow pipeline and scoreboard state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_p1       <= '0;
            wr_p1       <= 1'b0;
            ld_p1       <= 1'b0;
            rd_p2       <= '0;
            wr_p2       <= 1'b0;
            fwd_sel_p1  <= '0;
            busy        <= '0;
            long_cnt    <= '0;
            stall_cnt_q <= '0;
        end else begin
            rd_p2 <= rd_p1;
            wr_p2 <= wr_p1;
            if (adv_ex) begin
                rd_p1      <= sb.id_rd;
                wr_p1      <= sb.id_regwrite;
                ld_p1      <= sb.id_is_load;
                fwd_sel_p1 <= fwd_nxt;
            end else begin
                wr_p1      <= 1'b0;
                ld_p1      <= 1'b0;
                fwd_sel_p1 <= '0;
            end
            busy     <= busy_nxt;
            long_cnt <= long_cnt_nxt;
            if (stall_c) stall_cnt_q <= sat_inc16(stall_cnt_q);
        end
    end

    assign sb.stall     = stall_c;
    assign sb.fwd_sel   = fwd_sel_p1;
    assign sb.long_busy = busy;
    assign sb.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// ----------------------------------------------------------------------------
// tb_hazard_scoreboard
//   Directed bench for hazard_scoreboard (MAX_LONG=2). A behavioural model
//   tracks the EX/MEM occupants as records and outstanding long ops as a
//   queue of destinations; a negedge process compares every DUT output
//   against it each cycle, and literal expectations pin key scenarios.
// ----------------------------------------------------------------------------
module tb_hazard_scoreboard;
    localparam int NR = 32;
    localparam int RW = 5;
    localparam int NS = 2;
    localparam int ML = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.NUM_REGS(NR), .RW(RW), .NUM_SRC(NS)) sb_if ();

    hazard_scoreboard #(.NUM_REGS(NR), .RW(RW), .NUM_SRC(NS), .MAX_LONG(ML)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sb_if)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic       wr;
        logic       ld;
        logic [4:0] rd;
    } slot_t;

    slot_t      m_ex, m_mem;
    int         m_busy_q[$];
    logic [3:0] m_fwd;
    int         m_scnt;

    function automatic int src(input int i);
        return int'(sb_if.id_rs[i*RW +: RW]);
    endfunction

    function automatic bit m_is_busy(input int r);
        foreach (m_busy_q[k]) if (m_busy_q[k] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [NR-1:0] m_busy_vec();
        logic [NR-1:0] v;
        v = '0;
        foreach (m_busy_q[k]) v[m_busy_q[k]] = 1'b1;
        return v;
    endfunction

    function automatic bit m_stall();
        if (!rst_n || !sb_if.id_valid || sb_if.flush) return 1'b0;
        for (int i = 0; i < NS; i++) begin
            if (sb_if.id_rs_used[i] && src(i) != 0) begin
                if (m_ex.wr && m_ex.ld && int'(m_ex.rd) == src(i)) return 1'b1;
                if (m_is_busy(src(i))) return 1'b1;
            end
        end
        if ((sb_if.id_regwrite || sb_if.id_long) && sb_if.id_rd != 0 && m_is_busy(int'(sb_if.id_rd)))
            return 1'b1;
        if (sb_if.id_long && sb_if.id_rd != 0 && m_busy_q.size() == ML) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [1:0] m_sel(input int r);
        if (r != 0 && m_ex.wr && int'(m_ex.rd) == r)   return 2'b10;
        if (r != 0 && m_mem.wr && int'(m_mem.rd) == r) return 2'b01;
        return 2'b00;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ex  = '0;
            m_mem = '0;
            m_busy_q.delete();
            m_fwd  = '0;
            m_scnt = 0;
        end else begin
            bit         st;
            bit         iss;
            logic [3:0] f;
            st  = m_stall();
            iss = sb_if.id_valid && !st && !sb_if.flush;
            f   = {m_sel(src(1)), m_sel(src(0))};
            m_mem = m_ex;
            if (iss && !sb_if.id_long) begin
                m_ex.wr = sb_if.id_regwrite;
                m_ex.ld = sb_if.id_is_load;
                m_ex.rd = sb_if.id_rd;
                m_fwd   = f;
            end else begin
                m_ex  = '0;
                m_fwd = '0;
            end
            if (sb_if.lw_valid) begin
                for (int k = 0; k < m_busy_q.size(); k++) begin
                    if (m_busy_q[k] == int'(sb_if.lw_rd)) begin
                        m_busy_q.delete(k);
                        break;
                    end
                end
            end
            if (iss && sb_if.id_long && sb_if.id_rd != 0) m_busy_q.push_back(int'(sb_if.id_rd));
            if (st && m_scnt < 65535) m_scnt++;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("stall",     {63'd0, sb_if.stall}, {63'd0, m_stall()});
        check("fwd_sel",   64'(sb_if.fwd_sel),   64'(m_fwd));
        check("long_busy", 64'(sb_if.long_busy), 64'(m_busy_vec()));
        check("stall_cnt", 64'(sb_if.stall_cnt), 64'(m_scnt));
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sb_if.id_valid    = 1'b0;
        sb_if.id_rs       = '0;
        sb_if.id_rs_used  = '0;
        sb_if.id_rd       = '0;
        sb_if.id_regwrite = 1'b0;
        sb_if.id_is_load  = 1'b0;
        sb_if.id_long     = 1'b0;
        sb_if.flush       = 1'b0;
        sb_if.lw_valid    = 1'b0;
        sb_if.lw_rd       = '0;
    endtask

    task automatic instr(input int rd, input int rs0, input int rs1, input logic [1:0] used,
                         input bit regw, input bit ld, input bit lng);
        idle();
        sb_if.id_valid    = 1'b1;
        sb_if.id_rd       = 5'(rd);
        sb_if.id_rs       = {5'(rs1), 5'(rs0)};
        sb_if.id_rs_used  = used;
        sb_if.id_regwrite = regw;
        sb_if.id_is_load  = ld;
        sb_if.id_long     = lng;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_busy", 64'(sb_if.long_busy), 64'd0);
        check("rst_cnt",  64'(sb_if.stall_cnt), 64'd0);
        check("rst_fwd",  64'(sb_if.fwd_sel),   64'd0);
        rst_n = 1'b1;
        tick();

        // add x5 ; add x6,x5,x1 -> EX forward on operand 0
        instr(5, 1, 2, 2'b11, 1, 0, 0); tick();
        instr(6, 5, 1, 2'b11, 1, 0, 0); #1;
        check("alu_nostall", 64'(sb_if.stall), 64'd0);
        tick();
        check("ex_fwd_op0", 64'(sb_if.fwd_sel[1:0]), 64'h2);
        idle(); tick(); tick();

        // lw x7 ; sub x8,x2,x7 -> one bubble, then MEM/WB forward
        instr(7, 1, 2, 2'b11, 1, 1, 0); tick();
        instr(8, 2, 7, 2'b11, 1, 0, 0); #1;
        check("lu_stall", 64'(sb_if.stall), 64'd1);
        tick();
        check("lu_release", 64'(sb_if.stall), 64'd0);
        tick();
        check("lu_fwd", 64'(sb_if.fwd_sel), 64'h4);
        check("lu_cnt", 64'(sb_if.stall_cnt), 64'd1);
        idle(); tick(); tick();

        // add x3 ; or x3 ; and x4,x3,x3 -> newest producer on both operands
        instr(3, 1, 2, 2'b11, 1, 0, 0); tick();
        instr(3, 1, 2, 2'b11, 1, 0, 0); tick();
        instr(4, 3, 3, 2'b11, 1, 0, 0); #1;
        check("newest_nostall", 64'(sb_if.stall), 64'd0);
        tick();
        check("newest_fwd", 64'(sb_if.fwd_sel), 64'hA);
        idle(); tick(); tick();

        // mul x9 ; reader of x9 and writer of x9 stall until the writeback
        instr(9, 1, 2, 2'b11, 1, 0, 1); tick();
        check("mul_busy", 64'(sb_if.long_busy[9]), 64'd1);
        instr(10, 9, 1, 2'b11, 1, 0, 0); #1;
        check("raw_stall", 64'(sb_if.stall), 64'd1);
        tick();
        check("raw_stall2", 64'(sb_if.stall), 64'd1);
        tick();
        instr(9, 1, 2, 2'b11, 1, 0, 0); #1;
        check("waw_stall", 64'(sb_if.stall), 64'd1);
        tick();
        instr(10, 9, 1, 2'b11, 1, 0, 0);
        sb_if.lw_valid = 1'b1; sb_if.lw_rd = 5'd9; #1;
        check("lw_nobypass", 64'(sb_if.stall), 64'd1);
        tick();
        sb_if.lw_valid = 1'b0; #1;
        check("lw_release", 64'(sb_if.stall), 64'd0);
        check("lw_busy_clr", 64'(sb_if.long_busy[9]), 64'd0);
        tick();
        idle(); tick();

        // two long ops fill the slots; the third waits for a freed slot
        instr(11, 1, 2, 2'b11, 1, 0, 1); tick();
        instr(12, 1, 2, 2'b11, 1, 0, 1); tick();
        instr(13, 1, 2, 2'b11, 1, 0, 1); #1;
        check("full_stall", 64'(sb_if.stall), 64'd1);
        tick();
        sb_if.lw_valid = 1'b1; sb_if.lw_rd = 5'd11; #1;
        check("full_same_cycle", 64'(sb_if.stall), 64'd1);
        tick();
        sb_if.lw_valid = 1'b0; #1;
        check("full_freed", 64'(sb_if.stall), 64'd0);
        tick();
        check("busy_12_13", 64'(sb_if.long_busy), 64'h3000);

        // long op to x0 while full: no stall, no slot
        instr(0, 1, 2, 2'b11, 1, 0, 1); #1;
        check("long_x0_nostall", 64'(sb_if.stall), 64'd0);
        tick();
        check("long_x0_busy", 64'(sb_if.long_busy), 64'h3000);

        // ignored writebacks, then drain the scoreboard
        idle(); sb_if.lw_valid = 1'b1; sb_if.lw_rd = 5'd20; tick();
        sb_if.lw_rd = 5'd0;  tick();
        sb_if.lw_rd = 5'd12; tick();
        sb_if.lw_rd = 5'd13; tick();
        idle();
        check("drained", 64'(sb_if.long_busy), 64'd0);
        instr(14, 1, 2, 2'b11, 1, 0, 1); tick();
        instr(15, 1, 2, 2'b11, 1, 0, 1); #1;
        check("slot_after_free", 64'(sb_if.stall), 64'd0);
        tick();
        idle(); tick(); tick();

        // x0 producers never forward or stall
        instr(0, 1, 2, 2'b11, 1, 0, 0); tick();
        instr(0, 1, 2, 2'b11, 1, 1, 0); tick();
        instr(1, 0, 0, 2'b11, 1, 0, 0); #1;
        check("x0_nostall", 64'(sb_if.stall), 64'd0);
        tick();
        check("x0_nofwd", 64'(sb_if.fwd_sel), 64'd0);

        // unread operand matching a load does not stall
        instr(7, 1, 2, 2'b11, 1, 1, 0); tick();
        instr(8, 1, 7, 2'b01, 1, 0, 0); #1;
        check("unused_nostall", 64'(sb_if.stall), 64'd0);
        tick();
        idle(); tick(); tick();

        // flush during a load-use stall
        instr(7, 1, 2, 2'b11, 1, 1, 0); tick();
        instr(8, 2, 7, 2'b11, 1, 0, 0); #1;
        check("pre_flush_stall", 64'(sb_if.stall), 64'd1);
        sb_if.flush = 1'b1; #1;
        check("flush_stall0", 64'(sb_if.stall), 64'd0);
        tick();
        check("flush_bubble", 64'(sb_if.fwd_sel), 64'd0);
        check("flush_busy_kept", 64'(sb_if.long_busy), 64'hC000);

        // reset while stalled on a busy register
        instr(16, 14, 1, 2'b11, 1, 0, 0); #1;
        check("busy_stall", 64'(sb_if.stall), 64'd1);
        tick();
        rst_n = 1'b0; #1;
        check("mid_rst_busy",  64'(sb_if.long_busy), 64'd0);
        check("mid_rst_cnt",   64'(sb_if.stall_cnt), 64'd0);
        check("mid_rst_stall", 64'(sb_if.stall),     64'd0);
        tick();
        rst_n = 1'b1;
        idle(); tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
